led_seq_ctrl: RTL and testbench

Sequencer for the LED shift register in the TP3 LED shifter. It generates the one-cycle shift-enable strobe from a selectable-rate prescaler and owns the shift direction, which a push-button toggles. Switches drive enable and speed. Outputs connect directly to the shift register's shift-enable and direction inputs.

---
 rtl/led_seq_ctrl_pkg.sv | 22 ++
 rtl/led_seq_ctrl_if.sv | 21 ++
 rtl/led_seq_ctrl_btn_edge_sync.sv | 28 ++
 rtl/led_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_ctrl_pkg.sv
// rtl/led_seq_ctrl_pkg.sv - shared state encodings, direction codes and default limits for the LED sequencer
package led_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } seq_state_t;

  localparam logic DIR_DER = 1'b1;
  localparam logic DIR_IZQ = 1'b0;

  localparam int unsigned LIM0_DEF = 32'd1 << 23;
  localparam int unsigned LIM1_DEF = 32'd1 << 24;
  localparam int unsigned LIM2_DEF = 32'd1 << 25;
  localparam int unsigned LIM3_DEF = 32'd1 << 26;

  function automatic logic flip_dir(input logic dir);
    return (dir == DIR_DER) ? DIR_IZQ : DIR_DER;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// rtl/led_seq_ctrl_if.sv - switch, button and shift-register control signals of the LED sequencer
interface led_seq_ctrl_if;

  logic       i_enable;
  logic [1:0] i_speed_sel;
  logic       i_btn_dir;
  logic       o_shift_enable;
  logic       o_shift_dir;
  logic [1:0] o_state;

  modport master (
    output i_enable, i_speed_sel, i_btn_dir,
    input  o_shift_enable, o_shift_dir, o_state
  );

  modport slave (
    input  i_enable, i_speed_sel, i_btn_dir,
    output o_shift_enable, o_shift_dir, o_state
  );

endinterface

// File: rtl/led_seq_ctrl_btn_edge_sync.sv
// rtl/led_seq_ctrl_btn_edge_sync.sv - two-flop button synchronizer with a one-cycle rising-edge pulse
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // two flops for metastability, a third holds the previous synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - LED shift sequencer: prescaled shift strobe, run/hold FSM, direction toggle (option LED_SEQ_AUTOREV_EN)
module led_seq_ctrl
  import led_seq_ctrl_pkg::*;
#(
  parameter int unsigned N_LEDS = 4,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LIM0   = LIM0_DEF,
  parameter int unsigned LIM1   = LIM1_DEF,
  parameter int unsigned LIM2   = LIM2_DEF,
  parameter int unsigned LIM3   = LIM3_DEF
) (
  input  logic           clk,
  input  logic           i_ck_rst,
  led_seq_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] L0 = CNT_W'(LIM0);
  localparam logic [CNT_W-1:0] L1 = CNT_W'(LIM1);
  localparam logic [CNT_W-1:0] L2 = CNT_W'(LIM2);
  localparam logic [CNT_W-1:0] L3 = CNT_W'(LIM3);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] lim;
  logic [1:0]       speed_q;
  logic             speed_chg;
  logic             term;
  logic             strobe_nxt;
  logic             strobe_q;
  logic             dir_q;
  logic             btn_rise;

  btn_edge_sync u_btn_sync (
    .clk   (clk),
    .rst_n (i_ck_rst),
    .btn   (bus.i_btn_dir),
    .rise  (btn_rise)
  );

  // limit follows the registered speed, so a new selection applies the cycle after it is seen
  always_comb begin
    lim = L0;
    case (speed_q)
      2'd1:    lim = L1;
      2'd2:    lim = L2;
      2'd3:    lim = L3;
      default: lim = L0;
    endcase
  end

  assign speed_chg = (bus.i_speed_sel != speed_q);
  assign term      = (cnt == lim - CNT_W'(1));

  // next state, prescaler count and strobe request; a speed change wins over the terminal count
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    strobe_nxt = 1'b0;
    case (state)
      ST_RUN: begin
        if (!bus.i_enable) state_nxt = ST_HOLD;
        if (speed_chg) begin
          cnt_nxt = '0;
        end else if (term) begin
          cnt_nxt    = '0;
          strobe_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (bus.i_enable) state_nxt = ST_RUN;
        if (speed_chg) cnt_nxt = '0;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = bus.i_enable ? ST_RUN : ST_IDLE;
      end
    endcase
  end

  // state, prescaler, registered speed and strobe
  always_ff @(posedge clk or negedge i_ck_rst) begin
    if (!i_ck_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      speed_q  <= 2'd0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      speed_q  <= bus.i_speed_sel;
      strobe_q <= strobe_nxt;
    end
  end

`ifdef LED_SEQ_AUTOREV_EN
  localparam int unsigned     SC_W    = $clog2(N_LEDS);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(N_LEDS - 2);

  logic [SC_W-1:0] shift_cnt;

  // direction: button toggles, and after N_LEDS-1 strobes in one direction it reverses itself
  always_ff @(posedge clk or negedge i_ck_rst) begin
    if (!i_ck_rst) begin
      dir_q     <= DIR_IZQ;
      shift_cnt <= '0;
    end else if (btn_rise) begin
      dir_q     <= flip_dir(dir_q);
      shift_cnt <= '0;
    end else if (state == ST_IDLE) begin
      shift_cnt <= '0;
    end else if (strobe_q) begin
      if (shift_cnt == SC_LAST) begin
        dir_q     <= flip_dir(dir_q);
        shift_cnt <= '0;
      end else begin
        shift_cnt <= shift_cnt + SC_W'(1);
      end
    end
  end
`else
  // direction: toggled once per synchronized button rising edge
  always_ff @(posedge clk or negedge i_ck_rst) begin
    if (!i_ck_rst) begin
      dir_q <= DIR_IZQ;
    end else if (btn_rise) begin
      dir_q <= flip_dir(dir_q);
    end
  end
`endif

  assign bus.o_shift_enable = strobe_q;
  assign bus.o_shift_dir    = dir_q;
  assign bus.o_state        = state;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - self-checking bench for led_seq_ctrl: vector table, directed corners, random vs reference model
module tb_led_seq_ctrl;

  localparam int unsigned N_LEDS = 4;
  localparam int unsigned L0 = 4;
  localparam int unsigned L1 = 6;
  localparam int unsigned L2 = 8;
  localparam int unsigned L3 = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_seq_ctrl_if bus ();

  led_seq_ctrl #(
    .N_LEDS (N_LEDS),
    .CNT_W  (32),
    .LIM0   (L0),
    .LIM1   (L1),
    .LIM2   (L2),
    .LIM3   (L3)
  ) dut (
    .clk      (clk),
    .i_ck_rst (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic logic [7:0] outs();
    return 8'({bus.o_shift_enable, bus.o_shift_dir, bus.o_state});
  endfunction

  // reference model: mode 0 idle, 1 run, 2 hold; count runs modulo the limit
  int m_mode, m_cnt, m_spd;
  bit m_se, m_dir;
  bit h1, h2, h3;
`ifdef LED_SEQ_AUTOREV_EN
  int m_ar;
`endif

  function automatic int lim_of(input int sel);
    case (sel)
      1:       return int'(L1);
      2:       return int'(L2);
      3:       return int'(L3);
      default: return int'(L0);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_spd = 0; m_se = 1'b0; m_dir = 1'b0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
`ifdef LED_SEQ_AUTOREV_EN
    m_ar = 0;
`endif
  endtask

  task automatic model_edge(input bit en, input int sel, input bit btn);
    int lim;
    bit chg, rise, se_n;
    lim  = lim_of(m_spd);
    chg  = (sel != m_spd);
    rise = h2 && !h3;
    se_n = (m_mode == 1) && !chg && (m_cnt + 1 == lim);
    if (rise) begin
      m_dir = !m_dir;
`ifdef LED_SEQ_AUTOREV_EN
      m_ar = 0;
    end else if (m_mode == 0) begin
      m_ar = 0;
    end else if (m_se) begin
      m_ar = (m_ar + 1) % (int'(N_LEDS) - 1);
      if (m_ar == 0) m_dir = !m_dir;
`endif
    end
    if (m_mode == 0 || chg) m_cnt = 0;
    else if (m_mode == 1)   m_cnt = (m_cnt + 1) % lim;
    m_mode = en ? 1 : ((m_mode == 0) ? 0 : 2);
    m_spd  = sel;
    m_se   = se_n;
    h3 = h2; h2 = h1; h1 = btn;
  endtask

  function automatic logic [7:0] model_outs();
    return 8'({m_se, m_dir, 2'(m_mode)});
  endfunction

  task automatic drive(input bit en, input logic [1:0] sel, input bit btn);
    bus.i_enable    = en;
    bus.i_speed_sel = sel;
    bus.i_btn_dir   = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.i_enable, int'(bus.i_speed_sel), bus.i_btn_dir);
    #1;
    check("model", outs(), model_outs());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [1:0] sel;
    int         reps;
    bit         exp_se;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input bit en, input logic [1:0] sel, input int reps, input bit se, input logic [1:0] st);
    vec_t v;
    v.en = en; v.sel = sel; v.reps = reps; v.exp_se = se; v.exp_st = st;
    vt.push_back(v);
  endtask

  bit         r_en;
  logic [1:0] r_sel;
  bit         r_btn;

  initial begin
    drive(1'b0, 2'd0, 1'b0);
    do_reset();
    check("reset", outs(), 8'h00);

    // run at speed 0, hold/resume, speed change at count 2, speed change on a terminal count
    add_vec(1'b0, 2'd0,  2, 1'b0, 2'b00);
    add_vec(1'b1, 2'd0,  4, 1'b0, 2'b01);
    add_vec(1'b1, 2'd0,  1, 1'b1, 2'b01);
    add_vec(1'b1, 2'd0,  3, 1'b0, 2'b01);
    add_vec(1'b1, 2'd0,  1, 1'b1, 2'b01);
    add_vec(1'b1, 2'd0,  1, 1'b0, 2'b01);
    add_vec(1'b0, 2'd0, 10, 1'b0, 2'b10);
    add_vec(1'b1, 2'd0,  2, 1'b0, 2'b01);
    add_vec(1'b1, 2'd0,  1, 1'b1, 2'b01);
    add_vec(1'b1, 2'd0,  2, 1'b0, 2'b01);
    add_vec(1'b1, 2'd3,  1, 1'b0, 2'b01);
    add_vec(1'b1, 2'd3,  9, 1'b0, 2'b01);
    add_vec(1'b1, 2'd3,  1, 1'b1, 2'b01);
    add_vec(1'b1, 2'd3,  9, 1'b0, 2'b01);
    add_vec(1'b1, 2'd3,  1, 1'b1, 2'b01);
    add_vec(1'b1, 2'd3,  9, 1'b0, 2'b01);
    add_vec(1'b1, 2'd1,  1, 1'b0, 2'b01);
    add_vec(1'b1, 2'd1,  5, 1'b0, 2'b01);
    add_vec(1'b1, 2'd1,  1, 1'b1, 2'b01);

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].sel, 1'b0);
      for (int r = 0; r < vt[i].reps; r++) begin
        tick();
        check($sformatf("vec%0d.%0d", i, r), 8'({bus.o_shift_enable, bus.o_state}),
              8'({vt[i].exp_se, vt[i].exp_st}));
      end
    end

    // button in IDLE: 5-cycle press toggles once, 3 edges after the rise
    do_reset();
    drive(1'b0, 2'd0, 1'b1);
    tick(); check("btn_edge1", 8'(bus.o_shift_dir), 8'h0);
    tick(); check("btn_edge2", 8'(bus.o_shift_dir), 8'h0);
    tick(); check("btn_edge3", 8'(bus.o_shift_dir), 8'h1);
    repeat (2) tick();
    check("btn_held", 8'(bus.o_shift_dir), 8'h1);
    drive(1'b0, 2'd0, 1'b0);
    repeat (4) tick();
    check("btn_release", 8'(bus.o_shift_dir), 8'h1);
    drive(1'b0, 2'd0, 1'b1);
    repeat (3) tick();
    drive(1'b0, 2'd0, 1'b0);
    repeat (3) tick();
    check("btn_second", 8'(bus.o_shift_dir), 8'h0);

    // press timed so the toggle lands on the first strobe edge
    drive(1'b1, 2'd0, 1'b0);
    tick();
    tick();
    drive(1'b1, 2'd0, 1'b1);
    tick();
    drive(1'b1, 2'd0, 1'b0);
    tick();
    tick();
    check("strobe_new_dir", outs(), 8'b1101);

    // asynchronous reset during the strobe cycle
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), 8'h00);
    drive(1'b0, 2'd0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", outs(), 8'h00);
    drive(1'b1, 2'd0, 1'b0);
    tick();
    check("post_reset_run", outs(), 8'b0001);
    repeat (3) tick();
    check("post_reset_quiet", 8'(bus.o_shift_enable), 8'h0);
    tick();
    check("post_reset_strobe", 8'(bus.o_shift_enable), 8'h1);

`ifdef LED_SEQ_AUTOREV_EN
    // ping-pong: three strobes left, three right, then left again
    for (int k = 2; k <= 7; k++) begin
      repeat (4) tick();
      check($sformatf("autorev_strobe%0d", k), 8'({bus.o_shift_enable, bus.o_shift_dir}),
            8'({1'b1, 1'(((k - 1) / 3) % 2)}));
    end
`endif

    // randomized run against the reference model, with occasional bounces and resets
    do_reset();
    r_en = 1'b0; r_sel = 2'd0; r_btn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) r_en = ~r_en;
      if ($urandom_range(0, 39) == 0) r_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) r_btn = ~r_btn;
      drive(r_en, r_sel, r_btn);
      tick();
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_reset", outs(), 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
